y86_cc_unit: RTL and testbench

Condition-code unit for the pipelined Y86-64 execute stage. Holds the ZF/SF/OF condition-code register for each of NUM_CTX hardware contexts. Computes new flags from the ALU result of OPq instructions and commits them only when no later pipeline stage is raising an exception. Evaluates the jXX/cmovXX condition (ifun 0–6) against the selected context's flags, and supports direct register restore for context switch and interrupt return.

---
 rtl/y86_pkg.sv | 32 +++
 rtl/y86_cond_eval.sv | 28 ++
 rtl/y86_cc_unit.sv | 151 +++++++++++++++
 tb/tb_y86_cc_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline definitions: icodes, ALU functions, jXX/cmovXX conditions
// and the {ZF,SF,OF} condition-code record.
package y86_pkg;

  localparam logic [3:0] ICMOVXX = 4'h2;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;

  localparam logic [3:0] ALUADD = 4'h0;
  localparam logic [3:0] ALUSUB = 4'h1;
  localparam logic [3:0] ALUAND = 4'h2;
  localparam logic [3:0] ALUXOR = 4'h3;

  typedef enum logic [3:0] {
    C_YES = 4'h0,
    C_LE  = 4'h1,
    C_L   = 4'h2,
    C_E   = 4'h3,
    C_NE  = 4'h4,
    C_GE  = 4'h5,
    C_G   = 4'h6
  } cond_t;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = 3'b100;

endpackage

// File: rtl/y86_cond_eval.sv
// Combinational jXX/cmovXX condition evaluation from a CC record and ifun.
// Undefined conditions (ifun 7-15) evaluate false.
module y86_cond_eval
  import y86_pkg::*;
(
  input  cc_t        cc_i,
  input  logic [3:0] ifun_i,
  output logic       cnd_o
);

  logic lt;

  always_comb begin
    lt    = cc_i.sf ^ cc_i.of;
    cnd_o = 1'b0;
    case (ifun_i)
      C_YES:   cnd_o = 1'b1;
      C_LE:    cnd_o = lt | cc_i.zf;
      C_L:     cnd_o = lt;
      C_E:     cnd_o = cc_i.zf;
      C_NE:    cnd_o = ~cc_i.zf;
      C_GE:    cnd_o = ~lt;
      C_G:     cnd_o = ~lt & ~cc_i.zf;
      default: cnd_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/y86_cc_unit.sv
// Execute-stage condition-code unit: per-context ZF/SF/OF, restore port and condition eval.
// Optional CC_PERF_EN adds per-context saturating taken/not-taken branch counters.
module y86_cc_unit
  import y86_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int NUM_CTX = 1,
  parameter int CTX_W   = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [CTX_W-1:0]  ctx_sel,
  input  logic              e_valid,
  input  logic [3:0]        e_icode,
  input  logic [3:0]        e_ifun,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_valE,
  input  logic              m_exc,
  input  logic              w_exc,
  input  logic              cc_wr_en,
  input  logic [2:0]        cc_wr_data,
`ifdef CC_PERF_EN
  input  logic              perf_clr,
  output logic [CNT_W-1:0]  perf_taken,
  output logic [CNT_W-1:0]  perf_ntaken,
`endif
  output logic              e_cnd,
  output logic              cond_err,
  output logic [2:0]        cc_out
);

  cc_t  cc_q [NUM_CTX];
  cc_t  cc_d [NUM_CTX];
  cc_t  cc_cur;
  cc_t  cc_new;
  logic set_cc;
  logic of_new;
  logic a_msb, b_msb, v_msb;
  logic cnd_raw;
  logic unused_bits;

  assign a_msb = alu_a[DATA_W-1];
  assign b_msb = alu_b[DATA_W-1];
  assign v_msb = alu_valE[DATA_W-1];
  assign unused_bits = ^{alu_a[DATA_W-2:0], alu_b[DATA_W-2:0], CNT_W[0]};

  always_comb begin
    cc_cur = CC_RESET;
    for (int i = 0; i < NUM_CTX; i++) begin
      if (ctx_sel == CTX_W'(i)) cc_cur = cc_q[i];
    end
  end

  always_comb begin
    of_new = 1'b0;
    case (e_ifun)
      ALUADD:  of_new = (a_msb == b_msb) & (v_msb != a_msb);
      ALUSUB:  of_new = (a_msb != b_msb) & (v_msb != b_msb);
      default: of_new = 1'b0;
    endcase
  end

  assign cc_new = {(alu_valE == '0), v_msb, of_new};
  // OPq with an undefined ALU function leaves the flags alone; decode reports it.
  assign set_cc = e_valid & (e_icode == IOPQ) & (e_ifun <= ALUXOR) & ~m_exc & ~w_exc;

  always_comb begin
    for (int i = 0; i < NUM_CTX; i++) begin
      cc_d[i] = cc_q[i];
      if (ctx_sel == CTX_W'(i)) begin
        if (cc_wr_en)    cc_d[i] = cc_t'(cc_wr_data);
        else if (set_cc) cc_d[i] = cc_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CTX; i++) cc_q[i] <= CC_RESET;
    end else begin
      for (int i = 0; i < NUM_CTX; i++) cc_q[i] <= cc_d[i];
    end
  end

  y86_cond_eval u_cond (
    .cc_i   (cc_cur),
    .ifun_i (e_ifun),
    .cnd_o  (cnd_raw)
  );

  assign e_cnd    = e_valid & cnd_raw;
  assign cond_err = e_valid & ((e_icode == IJXX) | (e_icode == ICMOVXX)) & (e_ifun > 4'd6);
  assign cc_out   = cc_cur;

`ifdef CC_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] tk_q [NUM_CTX];
  logic [CNT_W-1:0] tk_d [NUM_CTX];
  logic [CNT_W-1:0] nt_q [NUM_CTX];
  logic [CNT_W-1:0] nt_d [NUM_CTX];
  logic             jxx_ok;

  assign jxx_ok = e_valid & (e_icode == IJXX) & (e_ifun <= 4'd6);

  always_comb begin
    for (int i = 0; i < NUM_CTX; i++) begin
      tk_d[i] = tk_q[i];
      nt_d[i] = nt_q[i];
      if (ctx_sel == CTX_W'(i)) begin
        if (perf_clr) begin
          tk_d[i] = '0;
          nt_d[i] = '0;
        end else if (jxx_ok && e_cnd && (tk_q[i] != CNT_MAX)) begin
          tk_d[i] = tk_q[i] + CNT_W'(1);
        end else if (jxx_ok && !e_cnd && (nt_q[i] != CNT_MAX)) begin
          nt_d[i] = nt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        tk_q[i] <= '0;
        nt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CTX; i++) begin
        tk_q[i] <= tk_d[i];
        nt_q[i] <= nt_d[i];
      end
    end
  end

  always_comb begin
    perf_taken  = '0;
    perf_ntaken = '0;
    for (int i = 0; i < NUM_CTX; i++) begin
      if (ctx_sel == CTX_W'(i)) begin
        perf_taken  = tk_q[i];
        perf_ntaken = nt_q[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_y86_cc_unit.sv
// Self-checking bench for y86_cc_unit: directed cases then randomized traffic against a flag model.
module tb_y86_cc_unit;
  import y86_pkg::*;

  localparam int DW = 64;
  localparam int NC = 4;
  localparam int CW = 2;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [CW-1:0] ctx_sel = '0;
  logic          e_valid = 1'b0;
  logic [3:0]    e_icode = '0;
  logic [3:0]    e_ifun = '0;
  logic [DW-1:0] alu_a = '0;
  logic [DW-1:0] alu_b = '0;
  logic [DW-1:0] alu_valE = '0;
  logic          m_exc = 1'b0;
  logic          w_exc = 1'b0;
  logic          cc_wr_en = 1'b0;
  logic [2:0]    cc_wr_data = '0;
  logic          e_cnd;
  logic          cond_err;
  logic [2:0]    cc_out;
`ifdef CC_PERF_EN
  logic          perf_clr = 1'b0;
  logic [NW-1:0] perf_taken;
  logic [NW-1:0] perf_ntaken;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [2:0] m_cc [NC];
  int         m_tk [NC];
  int         m_nt [NC];
  bit         model_live = 0;

  always #5 clk = ~clk;

  y86_cc_unit #(.DATA_W(DW), .NUM_CTX(NC), .CNT_W(NW)) dut (
`ifdef CC_PERF_EN
    .perf_clr    (perf_clr),
    .perf_taken  (perf_taken),
    .perf_ntaken (perf_ntaken),
`endif
    .clk         (clk),
    .reset_n     (reset_n),
    .ctx_sel     (ctx_sel),
    .e_valid     (e_valid),
    .e_icode     (e_icode),
    .e_ifun      (e_ifun),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_valE    (alu_valE),
    .m_exc       (m_exc),
    .w_exc       (w_exc),
    .cc_wr_en    (cc_wr_en),
    .cc_wr_data  (cc_wr_data),
    .e_cnd       (e_cnd),
    .cond_err    (cond_err),
    .cc_out      (cc_out)
  );

  function automatic logic [DW-1:0] m_val(logic [3:0] f, logic [DW-1:0] a, logic [DW-1:0] b);
    case (f)
      4'd0:    return b + a;
      4'd1:    return b - a;
      4'd2:    return a & b;
      4'd3:    return a ^ b;
      default: return '0;
    endcase
  endfunction

  // Overflow = true signed result does not fit in DW bits.
  function automatic bit m_of(logic [3:0] f, logic [DW-1:0] a, logic [DW-1:0] b);
    logic signed [DW:0] r;
    logic signed [DW:0] hi;
    logic signed [DW:0] lo;
    hi = {2'b00, {(DW-1){1'b1}}};
    lo = {2'b11, {(DW-1){1'b0}}};
    if (f == 4'd0)      r = $signed({a[DW-1], a}) + $signed({b[DW-1], b});
    else if (f == 4'd1) r = $signed({b[DW-1], b}) - $signed({a[DW-1], a});
    else return 1'b0;
    return (r > hi) || (r < lo);
  endfunction

  function automatic bit m_cond(logic [2:0] cc, logic [3:0] f);
    bit zf, lt;
    zf = cc[2];
    lt = (cc[1] != cc[0]);
    case (f)
      4'd0:    return 1'b1;
      4'd1:    return lt || zf;
      4'd2:    return lt;
      4'd3:    return zf;
      4'd4:    return !zf;
      4'd5:    return !lt;
      4'd6:    return !lt && !zf;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit exp_c, exp_err;
    if (!model_live) return;
    exp_c   = e_valid && m_cond(m_cc[ctx_sel], e_ifun);
    exp_err = e_valid && (e_icode == 4'd2 || e_icode == 4'd7) && (e_ifun > 4'd6);
    chk("cc_out", 64'(cc_out), 64'(m_cc[ctx_sel]));
    chk("e_cnd", 64'(e_cnd), 64'(exp_c));
    chk("cond_err", 64'(cond_err), 64'(exp_err));
`ifdef CC_PERF_EN
    chk("perf_taken", 64'(perf_taken), 64'(m_tk[ctx_sel]));
    chk("perf_ntaken", 64'(perf_ntaken), 64'(m_nt[ctx_sel]));
`endif
  endtask

  task automatic model_update();
    int c;
    bit jx, cnd, clr;
    c = int'(ctx_sel);
    if (!reset_n) begin
      for (int i = 0; i < NC; i++) begin
        m_cc[i] = 3'b100;
        m_tk[i] = 0;
        m_nt[i] = 0;
      end
      model_live = 1;
      return;
    end
    jx  = e_valid && (e_icode == 4'd7) && (e_ifun <= 4'd6);
    cnd = m_cond(m_cc[c], e_ifun);
    if (cc_wr_en)
      m_cc[c] = cc_wr_data;
    else if (e_valid && e_icode == 4'd6 && e_ifun <= 4'd3 && !m_exc && !w_exc)
      m_cc[c] = {alu_valE == '0, alu_valE[DW-1], m_of(e_ifun, alu_a, alu_b)};
    clr = 0;
`ifdef CC_PERF_EN
    clr = perf_clr;
`endif
    if (clr) begin
      m_tk[c] = 0;
      m_nt[c] = 0;
    end else if (jx) begin
      if (cnd) m_tk[c] = (m_tk[c] < (1 << NW) - 1) ? m_tk[c] + 1 : m_tk[c];
      else     m_nt[c] = (m_nt[c] < (1 << NW) - 1) ? m_nt[c] + 1 : m_nt[c];
    end
  endtask

  task automatic step();
    #1 check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    e_valid  = 1'b0;
    cc_wr_en = 1'b0;
    m_exc    = 1'b0;
    w_exc    = 1'b0;
`ifdef CC_PERF_EN
    perf_clr = 1'b0;
`endif
  endtask

  task automatic op(logic [CW-1:0] c, logic [3:0] f, logic [DW-1:0] a, logic [DW-1:0] b);
    ctx_sel  = c;
    e_valid  = 1'b1;
    e_icode  = 4'd6;
    e_ifun   = f;
    alu_a    = a;
    alu_b    = b;
    alu_valE = m_val(f, a, b);
  endtask

  task automatic br(logic [CW-1:0] c, logic [3:0] ic, logic [3:0] f);
    ctx_sel = c;
    e_valid = 1'b1;
    e_icode = ic;
    e_ifun  = f;
  endtask

  task automatic restore(logic [CW-1:0] c, logic [2:0] v);
    idle();
    ctx_sel    = c;
    cc_wr_en   = 1'b1;
    cc_wr_data = v;
    step();
    idle();
  endtask

  initial begin
    @(negedge clk);
    reset_n = 1'b0;
    idle();
    step();
    reset_n = 1'b1;

    br(0, 4'd7, 4'd3);
    #1 chk("reset_je", 64'(e_cnd), 64'd1);
    chk("reset_cc", 64'(cc_out), 64'h4);
    step();

    op(0, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    #1 chk("add_valE_no_bypass", 64'(cc_out), 64'h4);
    step();
    br(0, 4'd7, 4'd2);
    #1 chk("add_cc", 64'(cc_out), 64'h3);
    chk("add_jl", 64'(e_cnd), 64'd0);
    step();
    br(0, 4'd7, 4'd1);
    #1 chk("add_jle", 64'(e_cnd), 64'd0);
    step();
    br(0, 4'd7, 4'd5);
    #1 chk("add_jge", 64'(e_cnd), 64'd1);
    step();

    op(0, 4'd1, 64'd5, 64'd5);
    m_exc = 1'b1;
    step();
    idle();
    #1 chk("sub_mexc_hold", 64'(cc_out), 64'h3);
    step();
    op(0, 4'd1, 64'd5, 64'd5);
    w_exc = 1'b1;
    step();
    idle();
    #1 chk("sub_wexc_hold", 64'(cc_out), 64'h3);
    step();
    op(0, 4'd1, 64'd5, 64'd5);
    step();
    idle();
    #1 chk("sub_cc", 64'(cc_out), 64'h4);
    step();

    op(0, 4'd1, 64'd1, 64'd0);
    cc_wr_en   = 1'b1;
    cc_wr_data = 3'b001;
    step();
    idle();
    #1 chk("wr_beats_opq", 64'(cc_out), 64'h1);
    step();

    restore(1, 3'b010);
    restore(2, 3'b011);
    restore(3, 3'b011);
    op(2, 4'd3, 64'hDEAD_BEEF_0000_1234, 64'hDEAD_BEEF_0000_1234);
    step();
    idle();
    ctx_sel = 2;
    #1 chk("ctx2_xor", 64'(cc_out), 64'h4);
    ctx_sel = 0;
    #1 chk("ctx0_kept", 64'(cc_out), 64'h1);
    ctx_sel = 1;
    #1 chk("ctx1_kept", 64'(cc_out), 64'h2);
    ctx_sel = 3;
    #1 chk("ctx3_kept", 64'(cc_out), 64'h3);
    step();

    br(0, 4'd2, 4'd9);
    #1 chk("cmov9_err", 64'(cond_err), 64'd1);
    chk("cmov9_cnd", 64'(e_cnd), 64'd0);
    step();
    br(0, 4'd7, 4'd0);
    e_valid = 1'b0;
    #1 chk("bubble_cnd", 64'(e_cnd), 64'd0);
    step();

`ifdef CC_PERF_EN
    idle();
    ctx_sel  = 0;
    perf_clr = 1'b1;
    step();
    idle();
    for (int n = 0; n < 17; n++) begin
      br(0, 4'd7, 4'd0);
      step();
    end
    idle();
    #1 chk("perf_sat", 64'(perf_taken), 64'd15);
    br(0, 4'd7, 4'd0);
    perf_clr = 1'b1;
    step();
    idle();
    #1 chk("perf_clr_wins", 64'(perf_taken), 64'd0);
    step();
`endif

    restore(1, 3'b011);
    op(1, 4'd0, 64'd1, 64'd2);
    cc_wr_en = 1'b1;
    reset_n  = 1'b0;
    step();
    reset_n = 1'b1;
    idle();
    ctx_sel = 1;
    #1 chk("mid_reset", 64'(cc_out), 64'h4);
    step();

    for (int n = 0; n < 600; n++) begin
      logic [3:0]    ic, f;
      logic [DW-1:0] a, b;
      case ($urandom_range(0, 3))
        0:       ic = 4'd6;
        1:       ic = 4'd7;
        2:       ic = 4'd2;
        default: ic = 4'($urandom_range(0, 15));
      endcase
      f = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
          : (ic == 4'd6 ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 6)));
      case ($urandom_range(0, 3))
        0: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; end
        1: begin a = {$urandom, $urandom}; b = a; end
        2: begin a = 64'h8000_0000_0000_0000; b = ($urandom_range(0, 1) != 0) ? 64'h8000_0000_0000_0000 : 64'd1; end
        default: begin a = 64'($urandom_range(0, 3)); b = 64'h7FFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 2)); end
      endcase
      op(CW'($urandom_range(0, NC - 1)), f, a, b);
      e_icode    = ic;
      e_valid    = ($urandom_range(0, 7) != 0);
      m_exc      = ($urandom_range(0, 7) == 0);
      w_exc      = ($urandom_range(0, 7) == 0);
      cc_wr_en   = ($urandom_range(0, 9) == 0);
      cc_wr_data = 3'($urandom);
`ifdef CC_PERF_EN
      perf_clr   = ($urandom_range(0, 40) == 0);
`endif
      reset_n    = ($urandom_range(0, 99) != 0);
      step();
    end
    reset_n = 1'b1;
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
